// File: rtl/spart_echo_ctrl_if.sv
// SPART-side handshake and bus control signals of the echo controller.
// The 8-bit data bus is a separate inout port on the controller.
interface spart_echo_ctrl_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
   modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_echo_ctrl.sv
// SPART echo controller: programs the baud divisor, then copies received bytes
// through a small FIFO back out to the SPART transmitter.
//   state  | meaning
//   CFG_LO | divisor low-byte write (first cycle after reset only issues it)
//   CFG_HI | divisor high-byte write, latch baud select
//   IDLE   | no access; pick reconfig / read / write
//   RD     | data read from SPART into FIFO tail
//   WR     | FIFO head written to SPART
module spart_echo_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             i_br_cfg,
   spart_echo_ctrl_if.master      bus,
   inout  wire  [7:0]             io_databus,
   output logic                   o_cfg_done,
   output logic [$clog2(DEPTH):0] o_fifo_cnt
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW:0]     FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE = AW'(1);

   typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR} state_t;

   state_t          r_state, w_next;
   logic            r_iocs, r_iorw, w_iocs, w_iorw;
   logic [1:0]      r_ioaddr, w_ioaddr;
   logic [7:0]      r_wdata, w_wdata;
   logic [1:0]      r_cfg_sel, w_cfg_sel, r_br_cfg_q;
   logic            r_cfg_done;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [AW:0]     r_cnt;

   function automatic logic [7:0] f_div_lo(input logic [1:0] sel);
      case (sel)
         2'b00:   return 8'h16;
         2'b01:   return 8'h8B;
         2'b10:   return 8'h46;
         default: return 8'hA3;
      endcase
   endfunction

   function automatic logic [7:0] f_div_hi(input logic [1:0] sel);
      case (sel)
         2'b00:   return 8'h05;
         2'b01:   return 8'h02;
         2'b10:   return 8'h01;
         default: return 8'h00;
      endcase
   endfunction

   // Bus outputs are registered from the next state so they line up with r_state.
   always_comb begin
      w_next    = r_state;
      w_iocs    = 1'b0;
      w_iorw    = 1'b1;
      w_ioaddr  = r_ioaddr;
      w_wdata   = r_wdata;
      w_cfg_sel = r_cfg_sel;
      case (r_state)
         CFG_LO: begin
            if (!r_iocs) begin
               w_next    = CFG_LO;
               w_iocs    = 1'b1;
               w_iorw    = 1'b0;
               w_ioaddr  = 2'b10;
               w_wdata   = f_div_lo(i_br_cfg);
               w_cfg_sel = i_br_cfg;
            end else begin
               w_next   = CFG_HI;
               w_iocs   = 1'b1;
               w_iorw   = 1'b0;
               w_ioaddr = 2'b11;
               w_wdata  = f_div_hi(r_cfg_sel);
            end
         end
         CFG_HI: w_next = IDLE;
         IDLE: begin
            if (i_br_cfg != r_br_cfg_q) begin
               w_next    = CFG_LO;
               w_iocs    = 1'b1;
               w_iorw    = 1'b0;
               w_ioaddr  = 2'b10;
               w_wdata   = f_div_lo(i_br_cfg);
               w_cfg_sel = i_br_cfg;
            end else if (bus.rda && (r_cnt != FULL)) begin
               w_next   = RD;
               w_iocs   = 1'b1;
               w_ioaddr = 2'b00;
            end else if (bus.tbr && (r_cnt != '0)) begin
               w_next   = WR;
               w_iocs   = 1'b1;
               w_iorw   = 1'b0;
               w_ioaddr = 2'b00;
               w_wdata  = r_mem[r_rd_ptr];
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= CFG_LO;
         r_iocs     <= 1'b0;
         r_iorw     <= 1'b1;
         r_ioaddr   <= 2'b00;
         r_wdata    <= 8'h00;
         r_cfg_sel  <= 2'b00;
         r_br_cfg_q <= 2'b00;
         r_cfg_done <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
      end else begin
         r_state   <= w_next;
         r_iocs    <= w_iocs;
         r_iorw    <= w_iorw;
         r_ioaddr  <= w_ioaddr;
         r_wdata   <= w_wdata;
         r_cfg_sel <= w_cfg_sel;
         if (r_state == CFG_HI) begin
            r_br_cfg_q <= r_cfg_sel;
            r_cfg_done <= 1'b1;
         end else if ((r_state == IDLE) && (w_next == CFG_LO)) begin
            r_cfg_done <= 1'b0;
         end
         if (r_state == RD) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
            r_cnt    <= r_cnt + CNT_ONE;
         end else if (r_state == WR) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_cnt    <= r_cnt - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && (r_state == RD)) r_mem[r_wr_ptr] <= io_databus;
   end

   assign bus.iocs   = r_iocs;
   assign bus.iorw   = r_iorw;
   assign bus.ioaddr = r_ioaddr;
   assign io_databus = (r_iocs && !r_iorw) ? r_wdata : 8'hzz;
   assign o_cfg_done = r_cfg_done;
   assign o_fifo_cnt = r_cnt;

endmodule

// File: tb/tb_spart_echo_ctrl.sv
// Directed bench for spart_echo_ctrl with a small SPART receive/transmit model.
module tb_spart_echo_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] br_cfg;
   logic       tbr_v;
   logic       rda_v;
   logic [7:0] rx_head;
   logic       cfg_done;
   logic [2:0] fifo_cnt;
   wire  [7:0] databus;

   byte unsigned rx_q[$];
   logic [10:0]  log_q[$];
   bit           rd_pending = 1'b0;
   int           checks = 0;
   int           errors = 0;

   spart_echo_ctrl_if bus_if ();
   assign bus_if.rda = rda_v;
   assign bus_if.tbr = tbr_v;

   spart_echo_ctrl #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_br_cfg   (br_cfg),
      .bus        (bus_if),
      .io_databus (databus),
      .o_cfg_done (cfg_done),
      .o_fifo_cnt (fifo_cnt)
   );

   always #5 clk = ~clk;

   assign databus = (bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'b00) ? rx_head : 8'hzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup pu_db (databus[g]);
   end

   function automatic void rx_sync();
      rda_v   = (rx_q.size() != 0);
      rx_head = rda_v ? rx_q[0] : 8'h00;
   endfunction

   // SPART model: drop a byte one cycle after it was read, log every access
   always @(negedge clk) begin
      if (rd_pending && rx_q.size() != 0) begin
         void'(rx_q.pop_front());
         rx_sync();
      end
      rd_pending = bus_if.iocs && bus_if.iorw && (bus_if.ioaddr == 2'b00);
      if (bus_if.iocs) log_q.push_back({bus_if.iorw, bus_if.ioaddr, databus});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic offer(input byte unsigned b);
      rx_q.push_back(b);
      rx_sync();
   endtask

   task automatic wait_cnt(input logic [2:0] target, input int budget, input string tag);
      for (int i = 0; i < budget && fifo_cnt !== target; i++) step();
      chk(tag, fifo_cnt, target);
   endtask

   function automatic logic [10:0] log_at(input int i);
      return (log_q.size() > i) ? log_q[i] : 11'h7FF;
   endfunction

   function automatic logic [10:0] wr_e(input logic [1:0] a, input logic [7:0] d);
      return {1'b0, a, d};
   endfunction

   function automatic logic [10:0] rd_e(input logic [7:0] d);
      return {1'b1, 2'b00, d};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      br_cfg = 2'b01;
      tbr_v  = 1'b0;
      rx_sync();
      step(3);
      chk("rst_iocs", bus_if.iocs, 1'b1 ^ 1'b1);
      chk("rst_iorw", bus_if.iorw, 1'b1);
      chk("rst_addr", bus_if.ioaddr, 2'b00);
      chk("rst_bus", databus, 8'hFF);
      chk("rst_cfg_done", cfg_done, 1'b0);
      chk("rst_cnt", fifo_cnt, 3'd0);

      // reset release, br_cfg=01
      rst = 1'b0;
      step();
      chk("c1_iocs", bus_if.iocs, 1'b1);
      chk("c1_iorw", bus_if.iorw, 1'b0);
      chk("c1_addr", bus_if.ioaddr, 2'b10);
      chk("c1_data", databus, 8'h8B);
      chk("c1_cfg_done", cfg_done, 1'b0);
      step();
      chk("c2_iocs", bus_if.iocs, 1'b1);
      chk("c2_iorw", bus_if.iorw, 1'b0);
      chk("c2_addr", bus_if.ioaddr, 2'b11);
      chk("c2_data", databus, 8'h02);
      step();
      chk("c3_iocs", bus_if.iocs, 1'b0);
      chk("c3_iorw", bus_if.iorw, 1'b1);
      chk("c3_addr_hold", bus_if.ioaddr, 2'b11);
      chk("c3_cfg_done", cfg_done, 1'b1);

      // single-byte echo, cycle exact
      tbr_v = 1'b1;
      offer(8'h41);
      step();
      chk("e_rd_iocs", bus_if.iocs, 1'b1);
      chk("e_rd_iorw", bus_if.iorw, 1'b1);
      chk("e_rd_addr", bus_if.ioaddr, 2'b00);
      chk("e_rd_cnt", fifo_cnt, 3'd0);
      step();
      chk("e_gap_iocs", bus_if.iocs, 1'b0);
      chk("e_gap_cnt", fifo_cnt, 3'd1);
      step();
      chk("e_wr_iocs", bus_if.iocs, 1'b1);
      chk("e_wr_iorw", bus_if.iorw, 1'b0);
      chk("e_wr_addr", bus_if.ioaddr, 2'b00);
      chk("e_wr_data", databus, 8'h41);
      step();
      chk("e_end_iocs", bus_if.iocs, 1'b0);
      chk("e_end_cnt", fifo_cnt, 3'd0);
      chk("e_end_bus", databus, 8'hFF);

      // fill to DEPTH with tbr low, fifth byte stays pending
      tbr_v = 1'b0;
      log_q.delete();
      for (int i = 0; i < 5; i++) offer(8'h30 + 8'(i));
      wait_cnt(3'd4, 40, "full_cnt");
      step(4);
      chk("full_hold_cnt", fifo_cnt, 3'd4);
      chk("full_rda_pending", rda_v, 1'b1);
      chk("full_rx_left", rx_q.size(), 1);
      chk("full_reads", log_q.size(), 4);
      log_q.delete();
      tbr_v = 1'b1;
      wait_cnt(3'd0, 60, "drain_cnt");
      step(2);
      chk("drain_n", log_q.size(), 6);
      chk("drain_0", log_at(0), wr_e(2'b00, 8'h30));
      chk("drain_1", log_at(1), rd_e(8'h34));
      chk("drain_2", log_at(2), wr_e(2'b00, 8'h31));
      chk("drain_3", log_at(3), wr_e(2'b00, 8'h32));
      chk("drain_4", log_at(4), wr_e(2'b00, 8'h33));
      chk("drain_5", log_at(5), wr_e(2'b00, 8'h34));

      // rda and tbr together with one byte held: read wins
      tbr_v = 1'b0;
      offer(8'h50);
      wait_cnt(3'd1, 20, "prio_fill");
      step();
      log_q.delete();
      offer(8'h51);
      tbr_v = 1'b1;
      wait_cnt(3'd0, 40, "prio_drain");
      step(2);
      chk("prio_n", log_q.size(), 3);
      chk("prio_0", log_at(0), rd_e(8'h51));
      chk("prio_1", log_at(1), wr_e(2'b00, 8'h50));
      chk("prio_2", log_at(2), wr_e(2'b00, 8'h51));

      // baud change 01->11 with two bytes held
      tbr_v = 1'b0;
      offer(8'h60);
      offer(8'h61);
      wait_cnt(3'd2, 30, "recfg_fill");
      step();
      log_q.delete();
      br_cfg = 2'b11;
      tbr_v  = 1'b1;
      step();
      chk("recfg_done_low", cfg_done, 1'b0);
      chk("recfg_cnt_kept", fifo_cnt, 3'd2);
      wait_cnt(3'd0, 40, "recfg_drain");
      step(2);
      chk("recfg_n", log_q.size(), 4);
      chk("recfg_0", log_at(0), wr_e(2'b10, 8'hA3));
      chk("recfg_1", log_at(1), wr_e(2'b11, 8'h00));
      chk("recfg_2", log_at(2), wr_e(2'b00, 8'h60));
      chk("recfg_3", log_at(3), wr_e(2'b00, 8'h61));
      chk("recfg_done", cfg_done, 1'b1);

      // reset during a write
      tbr_v = 1'b0;
      offer(8'h70);
      wait_cnt(3'd1, 20, "rstwr_fill");
      step();
      tbr_v = 1'b1;
      step();
      chk("rstwr_iocs", bus_if.iocs, 1'b1);
      chk("rstwr_iorw", bus_if.iorw, 1'b0);
      rst = 1'b1;
      step();
      chk("rstwr_iocs_off", bus_if.iocs, 1'b0);
      chk("rstwr_cnt", fifo_cnt, 3'd0);
      chk("rstwr_cfg_done", cfg_done, 1'b0);
      chk("rstwr_bus", databus, 8'hFF);
      rst = 1'b0;
      log_q.delete();
      step(10);
      chk("rstwr_n", log_q.size(), 2);
      chk("rstwr_0", log_at(0), wr_e(2'b10, 8'hA3));
      chk("rstwr_1", log_at(1), wr_e(2'b11, 8'h00));
      chk("rstwr_end_cnt", fifo_cnt, 3'd0);
      chk("rstwr_end_done", cfg_done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
